pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter HANDLER_ADDR, default 32'h0000_0020, exception handler entry address.
REQ-002 SHALL have parameter STALL_LIMIT, default 8'd255, consecutive-stall cycles before the watchdog trips.
REQ-003 SHALL have port clock  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port stall_req_if  input  1  fetch stage stall request.
REQ-006 SHALL have port stall_req_id  input  1  decode stage stall request.
REQ-007 SHALL have port stall_req_ex  input  1  execute stage stall request (multi-cycle ops).
REQ-008 SHALL have port stall_req_mem  input  1  memory stage stall request.
REQ-009 SHALL have port exception_type_input  input  32  MEM-stage exception code; zero means none.
REQ-010 SHALL have port cp0_epc_input  input  32  EPC value for eret.
REQ-011 SHALL have port stop_all  output  6  stall vector: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 means Stop.
REQ-012 SHALL have port flush  output  1  pipeline flush pulse to all pipeline registers.
REQ-013 SHALL have port new_pc  output  32  redirect PC, valid only while flush=1.
REQ-014 SHALL have port stall_timeout  output  1  sticky watchdog flag.

Function
REQ-015 SHALL implement FSM states RUN, FLUSH, REFILL.
REQ-016 In RUN with exception_type_input != 0: flush=1 and new_pc driven combinationally in that cycle, stop_all=6'b000000, next state FLUSH.
REQ-017 new_pc SHALL be cp0_epc_input for code 32'h0000_000e (eret), else HANDLER_ADDR; 32'h0 when flush=0.
REQ-018 FLUSH SHALL last exactly one cycle, with flush=0 and stop_all=0; next state REFILL.
REQ-019 REFILL SHALL last one cycle: exceptions and stall requests ignored, stop_all=0; next state RUN.
REQ-020 In RUN, no exception: stop_all by priority mem > ex > id > if: 6'b011111, 6'b001111, 6'b000111, 6'b000011; none -> 6'b000000.
REQ-021 An exception SHALL override any simultaneous stall request.
REQ-022 An exception arriving in FLUSH or REFILL SHALL be ignored.
REQ-023 An 8-bit saturating counter SHALL increment each cycle stop_all != 0 and clear on any cycle stop_all == 0 or flush=1.
REQ-024 When the counter equals STALL_LIMIT, stall_timeout SHALL set and remain set until reset.

Reset
REQ-025 Reset SHALL force state RUN, counter 0, stall_timeout 0, and outputs stop_all=0, flush=0, new_pc=0 in the reset cycle.
REQ-026 Reset asserted in FLUSH or REFILL SHALL abandon the sequence, with no flush pulse after reset deasserts.

Configuration
REQ-027 Macro PIPELINE_CTRL_WATCHDOG_EN defined SHALL include the counter and stall_timeout logic per REQ-023/024.
REQ-028 Without PIPELINE_CTRL_WATCHDOG_EN, the counter SHALL be absent and stall_timeout SHALL be tied to 0.

Structure
REQ-029 The shared defines package SHALL hold the FSM state encodings, stop-vector constants, exception code constants, Stop/NoStop, and ZeroWord.
REQ-030 The stall-priority encoder SHALL be sub-module stall_encoder (four requests in, 6-bit vector out); all else inline.

Verification
REQ-031 Stalls: stall_req_ex=1 alone -> stop_all=6'b001111 same cycle; add stall_req_mem=1 -> 6'b011111.
REQ-032 Exception: exception_type_input=32'h8 together with stall_req_id=1 -> flush=1, new_pc=32'h20, stop_all=0, then FLUSH and REFILL with flush=0.
REQ-033 eret: exception_type_input=32'he, cp0_epc_input=32'h0000_1234 -> new_pc=32'h0000_1234 for one cycle.
REQ-034 Masking: exception held high for 3 cycles -> exactly one flush pulse; a new exception in the 4th cycle -> second pulse.
REQ-035 Watchdog: stall_req_id held 255 cycles -> stall_timeout=1 and stays 1 after release; with the macro undefined it stays 0.
REQ-036 Reset: reset asserted during FLUSH -> next cycle all outputs 0, state RUN, no pending flush.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared defines for the pipeline controller: FSM states, stop vectors,
// exception codes and common constants.
package pipeline_ctrl_pkg;

    localparam int unsigned STOP_W = 6;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FLUSH  = 2'd1,
        REFILL = 2'd2
    } state_t;

    // Stop vector bit order: {WB, MEM, EX, ID, IF, PC}
    localparam logic [STOP_W-1:0] STOP_NONE = 6'b000000;
    localparam logic [STOP_W-1:0] STOP_IF   = 6'b000011;
    localparam logic [STOP_W-1:0] STOP_ID   = 6'b000111;
    localparam logic [STOP_W-1:0] STOP_EX   = 6'b001111;
    localparam logic [STOP_W-1:0] STOP_MEM  = 6'b011111;

    localparam logic [WORD_W-1:0] EXC_NONE = 32'h0000_0000;
    localparam logic [WORD_W-1:0] EXC_ERET = 32'h0000_000e;

    localparam logic              STOP      = 1'b1;
    localparam logic              NO_STOP   = 1'b0;
    localparam logic [WORD_W-1:0] ZERO_WORD = 32'h0000_0000;

endpackage

// File: rtl/pipeline_ctrl_stall_encoder.sv
// Priority encoder turning per-stage stall requests into a stop vector
// (mem > ex > id > if); a stalled stage also stops everything upstream.
module stall_encoder
    import pipeline_ctrl_pkg::*;
(
    input  logic              stall_req_if,
    input  logic              stall_req_id,
    input  logic              stall_req_ex,
    input  logic              stall_req_mem,
    output logic [STOP_W-1:0] stop_vec
);

    always_comb begin
        stop_vec = STOP_NONE;
        if (stall_req_mem == STOP)
            stop_vec = STOP_MEM;
        else if (stall_req_ex == STOP)
            stop_vec = STOP_EX;
        else if (stall_req_id == STOP)
            stop_vec = STOP_ID;
        else if (stall_req_if == STOP)
            stop_vec = STOP_IF;
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/exception controller: stall vector, flush/redirect sequencing.
// Optional stall watchdog enabled by defining PIPELINE_CTRL_WATCHDOG_EN.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_0020,
    parameter logic [7:0]  STALL_LIMIT  = 8'd255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall_req_if,
    input  logic        stall_req_id,
    input  logic        stall_req_ex,
    input  logic        stall_req_mem,
    input  logic [31:0] exception_type_input,
    input  logic [31:0] cp0_epc_input,
    output logic [5:0]  stop_all,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        stall_timeout
);

    state_t            state_q;
    state_t            state_d;
    logic [STOP_W-1:0] enc_stop;

    stall_encoder u_stall_encoder (
        .stall_req_if  (stall_req_if),
        .stall_req_id  (stall_req_id),
        .stall_req_ex  (stall_req_ex),
        .stall_req_mem (stall_req_mem),
        .stop_vec      (enc_stop)
    );

    always_ff @(posedge clock) begin
        if (reset)
            state_q <= RUN;
        else
            state_q <= state_d;
    end

    // Outputs are combinational so a redirect or stall takes effect in the request cycle
    always_comb begin
        state_d  = state_q;
        stop_all = STOP_NONE;
        flush    = NO_STOP;
        new_pc   = ZERO_WORD;
        if (!reset) begin
            case (state_q)
                RUN: begin
                    if (exception_type_input != EXC_NONE) begin
                        flush   = 1'b1;
                        new_pc  = (exception_type_input == EXC_ERET) ? cp0_epc_input
                                                                     : HANDLER_ADDR;
                        state_d = FLUSH;
                    end else begin
                        stop_all = enc_stop;
                    end
                end
                FLUSH:   state_d = REFILL;
                REFILL:  state_d = RUN;
                default: state_d = RUN;
            endcase
        end
    end

`ifdef PIPELINE_CTRL_WATCHDOG_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;
    logic             timeout_q;

    // Saturating run-length of consecutive stalled cycles
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (flush || stop_all == STOP_NONE)
            stall_cnt_d = '0;
        else if (stall_cnt_q != {CNT_W{1'b1}})
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            if (stop_all != STOP_NONE && stall_cnt_d == STALL_LIMIT)
                timeout_q <= 1'b1;
        end
    end

    assign stall_timeout = timeout_q;
`else
    // Limit is only meaningful with the watchdog built in
    logic unused_stall_limit;
    assign unused_stall_limit = ^STALL_LIMIT;
    assign stall_timeout      = 1'b0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl; watchdog expectations
// follow PIPELINE_CTRL_WATCHDOG_EN.
module tb_pipeline_ctrl;

`ifdef PIPELINE_CTRL_WATCHDOG_EN
    localparam logic WD_EXP = 1'b1;
`else
    localparam logic WD_EXP = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic        stall_req_if;
    logic        stall_req_id;
    logic        stall_req_ex;
    logic        stall_req_mem;
    logic [31:0] exception_type_input;
    logic [31:0] cp0_epc_input;
    logic [5:0]  stop_all;
    logic        flush;
    logic [31:0] new_pc;
    logic        stall_timeout;

    int n_checks = 0;
    int n_pass   = 0;
    int n_pulses;

    pipeline_ctrl dut (
        .clock                (clock),
        .reset                (reset),
        .stall_req_if         (stall_req_if),
        .stall_req_id         (stall_req_id),
        .stall_req_ex         (stall_req_ex),
        .stall_req_mem        (stall_req_mem),
        .exception_type_input (exception_type_input),
        .cp0_epc_input        (cp0_epc_input),
        .stop_all             (stop_all),
        .flush                (flush),
        .new_pc               (new_pc),
        .stall_timeout        (stall_timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Advance one clock; inputs change 1ns after the edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [5:0] e_stop,
                              input logic e_flush, input logic [31:0] e_pc);
        check({tag, ".stop"},  32'(stop_all), 32'(e_stop));
        check({tag, ".flush"}, 32'(flush),    32'(e_flush));
        check({tag, ".pc"},    new_pc,        e_pc);
    endtask

    initial begin
        reset = 1'b1;
        stall_req_if = 1'b0;
        stall_req_id = 1'b0;
        stall_req_ex = 1'b0;
        stall_req_mem = 1'b1;
        exception_type_input = 32'h8;
        cp0_epc_input = 32'h0;
        #1;
        check_outs("reset_cycle", 6'b000000, 1'b0, 32'h0);
        tick();
        check("reset_timeout", 32'(stall_timeout), 32'h0);
        stall_req_mem = 1'b0;
        exception_type_input = 32'h0;
        tick();
        reset = 1'b0;
        #1;
        check_outs("idle", 6'b000000, 1'b0, 32'h0);

        // Stall priority
        stall_req_ex = 1'b1;  #1; check("stall_ex",     32'(stop_all), 32'h0f);
        stall_req_mem = 1'b1; #1; check("stall_ex_mem", 32'(stop_all), 32'h1f);
        tick();
        stall_req_mem = 1'b0; stall_req_ex = 1'b0; stall_req_id = 1'b1;
        #1; check("stall_id", 32'(stop_all), 32'h07);
        stall_req_if = 1'b1;  #1; check("stall_id_if", 32'(stop_all), 32'h07);
        stall_req_id = 1'b0;  #1; check("stall_if",    32'(stop_all), 32'h03);
        stall_req_if = 1'b0;  #1; check("stall_none",  32'(stop_all), 32'h00);
        tick();

        // Exception overrides a stall, then FLUSH and REFILL ignore stalls
        exception_type_input = 32'h8; stall_req_id = 1'b1;
        #1; check_outs("exc", 6'b000000, 1'b1, 32'h20);
        tick(); exception_type_input = 32'h0;
        #1; check_outs("exc_flush_st", 6'b000000, 1'b0, 32'h0);
        tick(); #1; check_outs("exc_refill_st", 6'b000000, 1'b0, 32'h0);
        tick(); #1; check_outs("exc_back_run", 6'b000111, 1'b0, 32'h0);
        stall_req_id = 1'b0;
        tick();

        // eret redirects to EPC for one cycle
        exception_type_input = 32'he; cp0_epc_input = 32'h0000_1234;
        #1; check_outs("eret", 6'b000000, 1'b1, 32'h0000_1234);
        tick(); exception_type_input = 32'h0;
        #1; check_outs("eret_after", 6'b000000, 1'b0, 32'h0);
        tick(); tick();

        // Exception held 3 cycles gives one pulse; 4th cycle gives another
        n_pulses = 0;
        exception_type_input = 32'h8;
        for (int i = 0; i < 3; i++) begin
            #1; if (flush) n_pulses++;
            tick();
        end
        check("mask_pulses", 32'(n_pulses), 32'd1);
        exception_type_input = 32'h4;
        #1; check_outs("mask_second", 6'b000000, 1'b1, 32'h20);
        tick(); exception_type_input = 32'h0;
        tick(); tick();

        // Reset during FLUSH abandons the sequence
        exception_type_input = 32'h8;
        #1; check("rst_pre_flush", 32'(flush), 32'h1);
        tick();
        exception_type_input = 32'h0; reset = 1'b1; stall_req_ex = 1'b1;
        #1; check_outs("rst_in_flush", 6'b000000, 1'b0, 32'h0);
        tick(); reset = 1'b0;
        #1; check_outs("rst_after", 6'b001111, 1'b0, 32'h0);
        stall_req_ex = 1'b0;
        tick();

        // Broken stall run restarts the watchdog count
        stall_req_id = 1'b1;
        repeat (200) tick();
        stall_req_id = 1'b0; tick();
        stall_req_id = 1'b1;
        repeat (100) tick();
        check("wd_broken_run", 32'(stall_timeout), 32'h0);
        stall_req_id = 1'b0; tick();

        // 255 consecutive stalled cycles trip the watchdog
        stall_req_id = 1'b1;
        repeat (254) tick();
        check("wd_254", 32'(stall_timeout), 32'h0);
        tick();
        check("wd_255", 32'(stall_timeout), 32'(WD_EXP));
        stall_req_id = 1'b0;
        repeat (3) tick();
        check("wd_sticky", 32'(stall_timeout), 32'(WD_EXP));
        reset = 1'b1; tick(); reset = 1'b0;
        #1; check("wd_reset_clr", 32'(stall_timeout), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
